logisim_input_conditioner: RTL
==============================

Name: logisim_input_conditioner

Overview:
- Conditions raw FPGA board inputs (buttons/switches) into clean logical levels for the `logisimInputBubbles` bus of the top-level Logisim circuit.
- Sits in the top-level shell between the board pins and the circuit instance, replacing the constant-0 tie-offs on that bus.
- Per channel: 2-flop synchroniser, polarity correction, and a tick-based debouncer.
- Also emits one-clock rise and fall pulses per channel.

Parameters:
- nrOfInputs, 5, number of conditioned channels; equals the width of `logisimInputBubbles`.
- activeLowMask, 5'b00000, per-bit polarity; 1 = board pin is active-low and is inverted after synchronisation.
- debounceTicks, 4, number of consecutive `fpgaTick` pulses a changed level must persist before it is accepted; legal range 1..(2^counterBits).
- counterBits, 3, width of each channel's debounce counter.

Ports:
- fpgaGlobalClock  in  1  single system clock; all logic is on its rising edge.
- fpgaGlobalResetN  in  1  synchronous, active-low reset.
- fpgaTick  in  1  one-clock enable pulse from the shell's tick generator; the debounce time base.
- fpgaInputs  in  nrOfInputs  raw asynchronous board pins.
- logisimInputBubbles  out  nrOfInputs  debounced, active-high logical levels to the circuit.
- inputRise  out  nrOfInputs  one-clock pulse when a channel's logical level goes 0->1.
- inputFall  out  nrOfInputs  one-clock pulse when a channel's logical level goes 1->0.

Behaviour:
- Reset (fpgaGlobalResetN=0 at a clock edge):
  - Both synchroniser stages of bit i load activeLowMask[i], so the logical level is 0.
  - Counters go to 0, all channels enter STABLE.
  - logisimInputBubbles=0, inputRise=0, inputFall=0.
  - Reset mid-debounce discards the pending change.
- Synchroniser:
  - sync2 <= sync1 <= fpgaInputs every clock, no enable.
  - Logical sample s[i] = sync2[i] XOR activeLowMask[i].
- Per-channel FSM, comparing s against the debounced output d:
  - STABLE: counter=0. If s != d, go to VERIFY. If a tick is present in that same cycle, counter <= 1; otherwise counter <= 0.
  - VERIFY:
    - If s == d in any cycle, go to STABLE and clear the counter, regardless of fpgaTick; mismatch loss wins over a simultaneous tick.
    - Else, on fpgaTick: when counter+1 == debounceTicks, d <= s, counter <= 0, go to STABLE, and pulse inputRise/inputFall for exactly that one clock. Otherwise counter <= counter+1.
    - Without a tick, hold.
  - With debounceTicks=1, the first tick seen with a mismatch, including the entering cycle, accepts the change.
- Latency from a pin change to the output update: 2 clocks of synchronisation, plus the time until debounceTicks ticks have occurred while the mismatch persists, plus the edge that updates d.
- Pulses: the outputs are registered.
  - inputRise[i] = 1 on the cycle d[i] first reads 1; inputFall[i] = 1 on the cycle d[i] first reads 0.
  - Both deassert the next cycle. They are never both high on one channel.
- Channels are fully independent; simultaneous changes on several channels each complete on their own schedule.
- Counter saturation is not needed: the counter never exceeds debounceTicks-1.
- Glitches shorter than one tick interval never reach the output if debounceTicks >= 2.

Test Plan:
- Reset, then hold fpgaInputs=5'b00000 with tick every 4 clocks for 50 clocks -> logisimInputBubbles stays 0; no pulses.
- Set bit0=1 and hold (debounceTicks=4, tick every 4 clocks, tick aligned to the 3rd clock after the pin change) -> bit0 rises exactly at the 4th tick after the mismatch; inputRise[0] high for one clock; inputFall stays 0.
- Bounce bit1: high for 5 clocks, low for 3, then high steady (tick every 4) -> the output updates only after 4 consecutive ticks of steady high; exactly one inputRise[1] pulse.
- activeLowMask=5'b00100:
  - Reset with pin2=1 -> output bit2=0.
  - Drive pin2=0 and hold -> bit2 goes to 1 after debounce, with an inputRise[2] pulse.
  - Return pin2=1 -> bit2 goes to 0 with an inputFall[2] pulse.
- Assert fpgaGlobalResetN=0 for 1 clock while bit3 is 2 ticks into VERIFY -> output 3 stays 0 and the counter restarts; with the pin still high, bit3 rises only after 4 further ticks.
- debounceTicks=1, change bits 0 and 4 on different clocks with tick every 8 -> each updates on the first tick after its own synchronised mismatch; pulses occur on separate cycles.

Source files
------------

// File: rtl/logisim_input_conditioner.sv
// logisim_input_conditioner
// Conditions raw board pins into clean, active-high logical levels for the
// logisimInputBubbles bus. Each channel passes through a two-flop synchroniser,
// an optional polarity inversion, and a tick-paced debouncer. The block also
// emits registered one-clock rise and fall pulses per channel.

module logisim_input_conditioner #(
  parameter int                    nrOfInputs    = 5,
  parameter logic [nrOfInputs-1:0] activeLowMask = '0,
  parameter int                    debounceTicks = 4,
  parameter int                    counterBits   = 3
) (
  input  logic                  fpgaGlobalClock,
  input  logic                  fpgaGlobalResetN,
  input  logic                  fpgaTick,
  input  logic [nrOfInputs-1:0] fpgaInputs,
  output logic [nrOfInputs-1:0] logisimInputBubbles,
  output logic [nrOfInputs-1:0] inputRise,
  output logic [nrOfInputs-1:0] inputFall
);

  typedef enum logic {
    STABLE = 1'b0,
    VERIFY = 1'b1
  } chan_state_e;

  // One bit wider than the counter so that debounceTicks == 2^counterBits
  // can still be compared against counter+1 without wrapping.
  localparam logic [counterBits:0] ticks_target = (counterBits + 1)'(debounceTicks);
  localparam logic [counterBits:0] one_ext      = (counterBits + 1)'(1);

  logic [nrOfInputs-1:0]  sync1_q, sync1_d;
  logic [nrOfInputs-1:0]  sync2_q, sync2_d;
  logic [nrOfInputs-1:0]  level_q, level_d;
  logic [nrOfInputs-1:0]  rise_q, rise_d;
  logic [nrOfInputs-1:0]  fall_q, fall_d;
  logic [nrOfInputs-1:0]  sample;
  chan_state_e            state_q [nrOfInputs];
  chan_state_e            state_d [nrOfInputs];
  logic [counterBits-1:0] cnt_q   [nrOfInputs];
  logic [counterBits-1:0] cnt_d   [nrOfInputs];
  logic [counterBits:0]   cnt_plus[nrOfInputs];

  // Logical sample after synchronisation; active-low pins are flipped here.
  assign sample = sync2_q ^ activeLowMask;

  // Synchroniser chain shifts every clock, no enable.
  always_comb begin
    sync1_d = fpgaInputs;
    sync2_d = sync1_q;
  end

  // Per-channel debounce: a mismatch must survive debounceTicks ticks in a row.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < nrOfInputs; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      cnt_plus[i] = {1'b0, cnt_q[i]} + one_ext;
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sample[i] != level_q[i]) begin
            if (fpgaTick && (ticks_target == one_ext)) begin
              level_d[i] = sample[i];
              rise_d[i]  = sample[i];
              fall_d[i]  = ~sample[i];
            end else if (fpgaTick) begin
              state_d[i] = VERIFY;
              cnt_d[i]   = counterBits'(1);
            end else begin
              state_d[i] = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (sample[i] == level_q[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (fpgaTick) begin
            if (cnt_plus[i] == ticks_target) begin
              state_d[i] = STABLE;
              cnt_d[i]   = '0;
              level_d[i] = sample[i];
              rise_d[i]  = sample[i];
              fall_d[i]  = ~sample[i];
            end else begin
              cnt_d[i] = cnt_plus[i][counterBits-1:0];
            end
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // All state registers; reset preloads the synchroniser so the level reads 0.
  always_ff @(posedge fpgaGlobalClock) begin
    if (!fpgaGlobalResetN) begin
      sync1_q <= activeLowMask;
      sync2_q <= activeLowMask;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < nrOfInputs; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < nrOfInputs; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign logisimInputBubbles = level_q;
  assign inputRise           = rise_q;
  assign inputFall           = fall_q;

endmodule
